// File: rtl/divisor_seq.sv
// divisor_seq: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock and a single-cycle done pulse carrying the result.
// Optional macro DIVISOR_SEQ_FAST_EN: divide-by-zero and signed overflow skip
// the iteration phase and finish one edge after acceptance.
module divisor_seq #(
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [SIZE-1:0] X,
   input  logic [SIZE-1:0] Y,
   output logic [SIZE-1:0] resultado,
   output logic            busy,
   output logic            done
);

   localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [CW-1:0]   LAST    = CW'(SIZE - 1);
   localparam logic [SIZE-1:0] MIN_VAL = {1'b1, {(SIZE-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, AJUSTE, FIM} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [SIZE-1:0] quo, rem, dvs, x_orig;
   logic            is_rem, sx, sq, dz, ovf;

   // operand conditioning for capture (op[0]=0 means signed)
   logic            signed_op, x_neg, y_neg, y_zero, ovf_in, special_in;
   logic [SIZE-1:0] x_abs, y_abs;

   assign signed_op  = ~op[0];
   assign x_neg      = signed_op & X[SIZE-1];
   assign y_neg      = signed_op & Y[SIZE-1];
   assign x_abs      = x_neg ? ('0 - X) : X;
   assign y_abs      = y_neg ? ('0 - Y) : Y;
   assign y_zero     = (Y == '0);
   assign ovf_in     = signed_op & (X == MIN_VAL) & (&Y);
   assign special_in = y_zero | ovf_in;

   // one restoring step: shifted remainder is SIZE+1 bits wide; the commit
   // value always fits SIZE bits because it is smaller than the divisor
   logic [SIZE:0]   trial;
   logic [SIZE-1:0] diff;
   logic            borrow;

   assign trial  = {rem, quo[SIZE-1]};
   assign borrow = (trial < {1'b0, dvs});
   assign diff   = trial[SIZE-1:0] - dvs;

   // sign fix-up and RISC-V special cases, selected in AJUSTE
   logic [SIZE-1:0] q_adj, r_adj, res_nx;

   always_comb begin
      q_adj = sq ? ('0 - quo) : quo;
      r_adj = sx ? ('0 - rem) : rem;
      res_nx = is_rem ? r_adj : q_adj;
      if (dz)
         res_nx = is_rem ? x_orig : '1;
      else if (ovf)
         res_nx = is_rem ? '0 : MIN_VAL;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state decode and status outputs
   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
`ifdef DIVISOR_SEQ_FAST_EN
               state_nx = special_in ? AJUSTE : CALC;
`else
               state_nx = CALC;
`endif
            end
         end
         CALC:    if (cnt == LAST) state_nx = AJUSTE;
         AJUSTE:  state_nx = FIM;
         FIM: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // datapath: capture on accept, iterate in CALC, load result in AJUSTE
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         quo       <= '0;
         rem       <= '0;
         dvs       <= '0;
         x_orig    <= '0;
         is_rem    <= 1'b0;
         sx        <= 1'b0;
         sq        <= 1'b0;
         dz        <= 1'b0;
         ovf       <= 1'b0;
         resultado <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               is_rem <= op[1];
               x_orig <= X;
               quo    <= x_abs;
               dvs    <= y_abs;
               sx     <= x_neg;
               sq     <= x_neg ^ y_neg;
               dz     <= y_zero;
               ovf    <= ovf_in;
               rem    <= '0;
               cnt    <= '0;
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (!borrow) begin
                  rem <= diff;
                  quo <= {quo[SIZE-2:0], 1'b1};
               end else begin
                  rem <= trial[SIZE-1:0];
                  quo <= {quo[SIZE-2:0], 1'b0};
               end
            end
            AJUSTE:  resultado <= res_nx;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_seq.sv
// tb_divisor_seq: directed vectors with hand-computed results for divisor_seq.
module tb_divisor_seq;

   localparam int LAT = 33;
`ifdef DIVISOR_SEQ_FAST_EN
   localparam int LAT_SP = 1;
`else
   localparam int LAT_SP = 33;
`endif

   logic        clk = 1'b0;
   logic        rst, start;
   logic [1:0]  op;
   logic [31:0] X, Y, resultado;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

   divisor_seq #(.SIZE(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .X(X), .Y(Y),
      .resultado(resultado), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // wait for done after the accepting edge; returns edges counted (0 on timeout)
   task automatic wait_done(input string tag, output int n);
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (done) begin n = i; break; end
      end
      if (n == 0) check({tag, " timeout"}, 32'd0, 32'd1);
   endtask

   // issue one op, scramble inputs after acceptance, check latency and result
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
      int n;
      @(negedge clk);
      op = o; X = x; Y = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; X = $urandom; Y = $urandom; op = 2'($urandom);
      check({tag, " busy"}, 32'(busy), 32'd1);
      wait_done(tag, n);
      if (n != 0) begin
         check({tag, " lat"}, 32'(n), 32'(lat));
         check({tag, " res"}, resultado, exp);
         @(posedge clk); #1;
         check({tag, " done fall"}, {31'd0, done}, 32'd0);
         check({tag, " busy fall"}, {31'd0, busy}, 32'd0);
         check({tag, " hold"}, resultado, exp);
      end
   endtask

   initial begin
      int n, dn;
      rst = 1'b1; start = 1'b0; op = 2'b00; X = '0; Y = '0;
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      check("rst res", resultado, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);

      do_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, LAT);
      do_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, LAT);
      do_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
      do_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
      do_op("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT);
      do_op("div -100/-7", DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, LAT);
      do_op("divu big", DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, LAT);
      do_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SP);
      do_op("rem -5/0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_SP);
      do_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP);
      do_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SP);

      // reset mid-operation aborts with no done pulse
      do_op("pre abort", DIVU, 32'd100, 32'd7, 32'd14, LAT);
      @(negedge clk);
      op = DIVU; X = 32'd100; Y = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort res", resultado, 32'd0);
      @(negedge clk); rst = 1'b0;
      dn = 0;
      repeat (40) begin @(posedge clk); #1; if (done) dn++; end
      check("abort no done", 32'(dn), 32'd0);
      do_op("divu 9/3", DIVU, 32'd9, 32'd3, 32'd3, LAT);

      // start held high with changing operands: only the first op completes
      @(negedge clk);
      op = DIVU; X = 32'd100; Y = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      op = REMU; X = 32'd9; Y = 32'd3;
      wait_done("held", n);
      check("held lat", 32'(n), 32'(LAT));
      check("held res", resultado, 32'd14);
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      check("held fim busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk); #1;
      check("held idle", {31'd0, busy}, 32'd0);

      // back-to-back: start during FIM is ignored, accepted at the IDLE edge
      @(negedge clk);
      op = DIVU; X = 32'd100; Y = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("b2b first", n);
      check("b2b first res", resultado, 32'd14);
      @(negedge clk);
      op = REMU; X = 32'd100; Y = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      check("b2b fim ignored", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b accepted", {31'd0, busy}, 32'd1);
      wait_done("b2b second", n);
      check("b2b second lat", 32'(n), 32'(LAT));
      check("b2b second res", resultado, 32'd2);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
